// File: rtl/sha2_pad_ctrl.sv
// SHA-2 padding sequencer: steers the packet mux (pad / zero / length) so every message fills whole blocks.
// Optional empty-message start is enabled by defining SHA2_PAD_EMPTY_MSG_EN.
module sha2_pad_ctrl #(
  parameter int w   = 64,
  parameter int WPB = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef SHA2_PAD_EMPTY_MSG_EN
  input  logic                   empty_start,
`endif
  output logic                   pad_pkt,
  output logic                   zero_pkt,
  output logic                   mgln_pkt,
  output logic [w-1:0]           msg_len,
  output logic [$clog2(WPB)-1:0] word_idx,
  output logic                   blk_last,
  output logic                   msg_done
);

  localparam int IDXW = $clog2(WPB);

  localparam logic [1:0] ST_MSG  = 2'd0;
  localparam logic [1:0] ST_PAD  = 2'd1;
  localparam logic [1:0] ST_ZERO = 2'd2;
  localparam logic [1:0] ST_LEN  = 2'd3;

  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(WPB - 1);
  localparam logic [IDXW-1:0] IDX_ONE   = IDXW'(1);
  localparam logic [w-1:0]    WORD_BITS = w'(w);

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [IDXW-1:0] word_idx_r;
  logic [IDXW-1:0] idx_nxt_s;
  logic [IDXW-1:0] idx_inc_s;
  logic [w-1:0]    msg_len_r;
  logic [w-1:0]    len_nxt_s;
  logic            empty_go_s;
  logic            out_valid_s;
  logic            in_ready_s;
  logic            xfer_s;

`ifdef SHA2_PAD_EMPTY_MSG_EN
  // An empty message can only start before any word of the current message was taken.
  assign empty_go_s = empty_start && (state_r == ST_MSG) &&
                      (word_idx_r == {IDXW{1'b0}}) && (msg_len_r == {w{1'b0}});
`else
  assign empty_go_s = 1'b0;
`endif

  assign idx_inc_s = word_idx_r + IDX_ONE;
  assign xfer_s    = out_valid_s && out_ready;

  // Output handshake and mux selects decoded from the registered state.
  always_comb begin
    out_valid_s = 1'b0;
    in_ready_s  = 1'b0;
    pad_pkt     = 1'b0;
    zero_pkt    = 1'b0;
    mgln_pkt    = 1'b0;
    msg_done    = 1'b0;
    case (state_r)
      ST_MSG: begin
        // Hold the host off while an empty message is being launched.
        out_valid_s = in_valid && !empty_go_s;
        in_ready_s  = out_ready && !empty_go_s;
      end
      ST_PAD: begin
        out_valid_s = 1'b1;
        pad_pkt     = 1'b1;
      end
      ST_ZERO: begin
        out_valid_s = 1'b1;
        zero_pkt    = 1'b1;
      end
      ST_LEN: begin
        out_valid_s = 1'b1;
        mgln_pkt    = 1'b1;
        msg_done    = 1'b1;
      end
      default: begin
        out_valid_s = 1'b0;
        in_ready_s  = 1'b0;
      end
    endcase
  end

  // Next-state, slot index and length update; everything holds without a transfer.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = word_idx_r;
    len_nxt_s   = msg_len_r;
    case (state_r)
      ST_MSG: begin
        if (empty_go_s) begin
          state_nxt_s = ST_PAD;
        end else if (xfer_s) begin
          idx_nxt_s = idx_inc_s;
          len_nxt_s = msg_len_r + WORD_BITS;
          if (in_last) begin
            state_nxt_s = ST_PAD;
          end else begin
            state_nxt_s = ST_MSG;
          end
        end else begin
          state_nxt_s = ST_MSG;
        end
      end
      ST_PAD, ST_ZERO: begin
        if (xfer_s) begin
          idx_nxt_s = idx_inc_s;
          if (idx_inc_s == IDX_LAST) begin
            state_nxt_s = ST_LEN;
          end else begin
            state_nxt_s = ST_ZERO;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LEN: begin
        if (xfer_s) begin
          state_nxt_s = ST_MSG;
          idx_nxt_s   = {IDXW{1'b0}};
          len_nxt_s   = {w{1'b0}};
        end else begin
          state_nxt_s = ST_LEN;
        end
      end
      default: begin
        state_nxt_s = ST_MSG;
        idx_nxt_s   = {IDXW{1'b0}};
        len_nxt_s   = {w{1'b0}};
      end
    endcase
  end

  // State registers with synchronous reset that overrides any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_MSG;
      word_idx_r <= {IDXW{1'b0}};
      msg_len_r  <= {w{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      word_idx_r <= idx_nxt_s;
      msg_len_r  <= len_nxt_s;
    end
  end

  assign out_valid = out_valid_s;
  assign in_ready  = in_ready_s;
  assign word_idx  = word_idx_r;
  assign msg_len   = msg_len_r;
  assign blk_last  = out_valid_s && (word_idx_r == IDX_LAST);

endmodule
